// File: rtl/clock_set_ctrl.sv
// Hour/minute/second timekeeper with a button-driven set-mode FSM and per-digit blink masks
// for the six-digit seven-segment display path.
module clock_set_ctrl #(
  parameter int BLINK_DIV = 25000000,
  parameter int HOUR_MAX  = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick_1hz,
  input  logic       i_btn_mode,
  input  logic       i_btn_pos,
  input  logic       i_btn_up,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [5:0] o_hour,
  output logic [1:0] o_mode,
  output logic [5:0] o_blink_mask,
  output logic       o_carry_day
);

  typedef enum logic [1:0] {
    CLOCK    = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } mode_t;

  localparam int            CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [5:0]    HOUR_LAST  = 6'(HOUR_MAX);

  mode_t         state_q, state_d;
  logic [5:0]    sec_d, min_d, hour_d, mask_d;
  logic          carry_d;
  logic          mode_prev, pos_prev, up_prev;
  logic          mode_press, pos_press, up_press;
  logic [CW-1:0] blink_cnt, blink_cnt_d;
  logic          blink_phase, blink_phase_d;

  // Edge detect with fixed priority mode > pos > up; losers in the same cycle are discarded.
  assign mode_press = i_btn_mode & ~mode_prev;
  assign pos_press  = i_btn_pos & ~pos_prev & ~mode_press;
  assign up_press   = i_btn_up & ~up_prev & ~mode_press & ~pos_press;

  assign o_mode = state_q;

  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] last);
    return (v >= last) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    sec_d   = o_sec;
    min_d   = o_min;
    hour_d  = o_hour;
    carry_d = 1'b0;
    case (state_q)
      CLOCK: begin
        if (mode_press) state_d = SET_SEC;
        if (i_tick_1hz) begin
          sec_d = inc_wrap(o_sec, 6'd59);
          if (o_sec >= 6'd59) begin
            min_d = inc_wrap(o_min, 6'd59);
            if (o_min >= 6'd59) begin
              hour_d  = inc_wrap(o_hour, HOUR_LAST);
              carry_d = (o_hour >= HOUR_LAST);
            end
          end
        end
      end
      default: begin
        // Set states freeze time: ticks are dropped, up edits one field with no carry.
        if (mode_press) begin
          state_d = CLOCK;
        end else if (pos_press) begin
          case (state_q)
            SET_SEC: state_d = SET_MIN;
            SET_MIN: state_d = SET_HOUR;
            default: state_d = SET_SEC;
          endcase
        end else if (up_press) begin
          case (state_q)
            SET_SEC: sec_d  = inc_wrap(o_sec, 6'd59);
            SET_MIN: min_d  = inc_wrap(o_min, 6'd59);
            default: hour_d = inc_wrap(o_hour, HOUR_LAST);
          endcase
        end
      end
    endcase
  end

  always_comb begin
    blink_cnt_d   = blink_cnt + CW'(1);
    blink_phase_d = blink_phase;
    if (state_d != state_q) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase;
    end
    mask_d = 6'b000000;
    if (blink_phase_d) begin
      case (state_d)
        SET_SEC:  mask_d = 6'b000011;
        SET_MIN:  mask_d = 6'b001100;
        SET_HOUR: mask_d = 6'b110000;
        default:  mask_d = 6'b000000;
      endcase
    end
  end

  // Button history resets to 1 so a button held through reset must be re-pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLOCK;
      o_sec        <= '0;
      o_min        <= '0;
      o_hour       <= '0;
      o_carry_day  <= 1'b0;
      o_blink_mask <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      mode_prev    <= 1'b1;
      pos_prev     <= 1'b1;
      up_prev      <= 1'b1;
    end else begin
      state_q      <= state_d;
      o_sec        <= sec_d;
      o_min        <= min_d;
      o_hour       <= hour_d;
      o_carry_day  <= carry_d;
      o_blink_mask <= mask_d;
      blink_cnt    <= blink_cnt_d;
      blink_phase  <= blink_phase_d;
      mode_prev    <= i_btn_mode;
      pos_prev     <= i_btn_pos;
      up_prev      <= i_btn_up;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: a time/blink reference model feeds a scoreboard queue,
// plus directed checks at the key points of each scenario.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, bm, bp, bu;
  logic [5:0] o_sec, o_min, o_hour, o_blink_mask;
  logic [1:0] o_mode;
  logic       o_carry_day;

  clock_set_ctrl #(.BLINK_DIV(4), .HOUR_MAX(23)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_tick_1hz   (tick),
    .i_btn_mode   (bm),
    .i_btn_pos    (bp),
    .i_btn_up     (bu),
    .o_sec        (o_sec),
    .o_min        (o_min),
    .o_hour       (o_hour),
    .o_mode       (o_mode),
    .o_blink_mask (o_blink_mask),
    .o_carry_day  (o_carry_day)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sec, min, hour, mask;
    logic [1:0] mode;
    logic       carry;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_t, m_mode, m_bcnt;
  bit   m_phase, m_pm, m_pp, m_pu;

  task automatic checkValue(input string tag, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    assert (act === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // Model holds time as seconds-of-day so its arithmetic is independent of the digit counters.
  task automatic modelStep(input bit t, input bit m, input bit p, input bit u);
    bit   mp, pp, up;
    int   s, mi, h, old_mode;
    exp_t e;
    mp = m & !m_pm;
    pp = p & !m_pp & !mp;
    up = u & !m_pu & !mp & !pp;
    m_pm = m; m_pp = p; m_pu = u;
    old_mode = m_mode;
    e.carry = 1'b0;
    if (m_mode == 0) begin
      if (t) begin
        if (m_t == 86399) begin m_t = 0; e.carry = 1'b1; end
        else m_t++;
      end
      if (mp) m_mode = 1;
    end else if (mp) begin
      m_mode = 0;
    end else if (pp) begin
      m_mode = (m_mode == 3) ? 1 : m_mode + 1;
    end else if (up) begin
      s = m_t % 60; mi = (m_t / 60) % 60; h = m_t / 3600;
      if (m_mode == 1) s = (s + 1) % 60;
      else if (m_mode == 2) mi = (mi + 1) % 60;
      else h = (h + 1) % 24;
      m_t = h * 3600 + mi * 60 + s;
    end
    if (m_mode != old_mode) begin m_bcnt = 0; m_phase = 1'b0; end
    else if (m_bcnt == 3) begin m_bcnt = 0; m_phase = !m_phase; end
    else m_bcnt++;
    e.sec  = 6'(m_t % 60);
    e.min  = 6'((m_t / 60) % 60);
    e.hour = 6'(m_t / 3600);
    e.mode = 2'(m_mode);
    e.mask = (m_mode == 0 || !m_phase) ? 6'd0 : 6'(3 << (2 * (m_mode - 1)));
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s.queue: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    checkValue({tag, ".sec"},   o_sec,  e.sec);
    checkValue({tag, ".min"},   o_min,  e.min);
    checkValue({tag, ".hour"},  o_hour, e.hour);
    checkValue({tag, ".mode"},  {4'b0, o_mode}, {4'b0, e.mode});
    checkValue({tag, ".mask"},  o_blink_mask, e.mask);
    checkValue({tag, ".carry"}, {5'b0, o_carry_day}, {5'b0, e.carry});
  endtask

  task automatic applyStimulus(input bit t, input bit m, input bit p, input bit u, input string tag);
    tick = t; bm = m; bp = p; bu = u;
    modelStep(t, m, p, u);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic press(input bit m, input bit p, input bit u, input string tag);
    applyStimulus(1'b0, m, p, u, tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Reset is asserted between edges and checked before the next edge to prove it is asynchronous.
  task automatic doReset(input bit hold_mode, input string tag);
    rst = 1'b1; bm = hold_mode; bp = 1'b0; bu = 1'b0; tick = 1'b0;
    #1;
    checkValue({tag, ".sec"},   o_sec, 6'd0);
    checkValue({tag, ".min"},   o_min, 6'd0);
    checkValue({tag, ".hour"},  o_hour, 6'd0);
    checkValue({tag, ".mode"},  {4'b0, o_mode}, 6'd0);
    checkValue({tag, ".mask"},  o_blink_mask, 6'd0);
    checkValue({tag, ".carry"}, {5'b0, o_carry_day}, 6'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_t = 0; m_mode = 0; m_bcnt = 0; m_phase = 1'b0;
    m_pm = 1'b1; m_pp = 1'b1; m_pu = 1'b1;
    sb.delete();
  endtask

  initial begin
    $display("[TB] start");
    doReset(1'b0, "t1.reset");

    repeat (125) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t1.tick");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t1.idle");
    end
    checkValue("t1.sec", o_sec, 6'd5);
    checkValue("t1.min", o_min, 6'd2);
    checkValue("t1.hour", o_hour, 6'd0);
    checkValue("t1.mode", {4'b0, o_mode}, 6'd0);
    checkValue("t1.mask", o_blink_mask, 6'd0);

    press(1'b1, 1'b0, 1'b0, "t2.mode");
    repeat (53) press(1'b0, 1'b0, 1'b1, "t2.upsec");
    press(1'b0, 1'b1, 1'b0, "t2.pos");
    repeat (57) press(1'b0, 1'b0, 1'b1, "t2.upmin");
    press(1'b0, 1'b1, 1'b0, "t2.pos");
    repeat (23) press(1'b0, 1'b0, 1'b1, "t2.uphour");
    press(1'b1, 1'b0, 1'b0, "t2.mode");
    checkValue("t2.preload.sec", o_sec, 6'd58);
    checkValue("t2.preload.min", o_min, 6'd59);
    checkValue("t2.preload.hour", o_hour, 6'd23);
    checkValue("t2.preload.mode", {4'b0, o_mode}, 6'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t2.tick59");
    checkValue("t2.s59.sec", o_sec, 6'd59);
    checkValue("t2.s59.carry", {5'b0, o_carry_day}, 6'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t2.wrap");
    checkValue("t2.wrap.sec", o_sec, 6'd0);
    checkValue("t2.wrap.min", o_min, 6'd0);
    checkValue("t2.wrap.hour", o_hour, 6'd0);
    checkValue("t2.wrap.carry", {5'b0, o_carry_day}, 6'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t2.after");
    checkValue("t2.after.carry", {5'b0, o_carry_day}, 6'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "t3.tickmode");
    checkValue("t3.tickmode.sec", o_sec, 6'd1);
    checkValue("t3.tickmode.mode", {4'b0, o_mode}, 6'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t3.rel");
    press(1'b0, 1'b1, 1'b0, "t3.pos");
    press(1'b0, 1'b1, 1'b0, "t3.pos");
    checkValue("t3.mode", {4'b0, o_mode}, 6'd3);
    repeat (25) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t3.up");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t3.settick");
    end
    checkValue("t3.hour", o_hour, 6'd1);
    checkValue("t3.min", o_min, 6'd0);
    checkValue("t3.sec", o_sec, 6'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "t3.tickexit");
    checkValue("t3.tickexit.sec", o_sec, 6'd1);
    checkValue("t3.tickexit.mode", {4'b0, o_mode}, 6'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t3.rel");

    press(1'b1, 1'b0, 1'b0, "t4.mode");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "t4.pos");
    checkValue("t4.mode", {4'b0, o_mode}, 6'd2);
    checkValue("t4.mask0", o_blink_mask, 6'd0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t4.blink");
      checkValue($sformatf("t4.blink%0d", k), o_blink_mask, ((k / 4) % 2 == 1) ? 6'b001100 : 6'b000000);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "t4.posblank");
    checkValue("t4.posblank.mode", {4'b0, o_mode}, 6'd3);
    checkValue("t4.posblank.mask", o_blink_mask, 6'd0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t4.hourblink");
    checkValue("t4.hourmask", o_blink_mask, 6'b110000);
    press(1'b1, 1'b0, 1'b0, "t4.exit");

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "t5.all");
    checkValue("t5.all.mode", {4'b0, o_mode}, 6'd1);
    checkValue("t5.all.sec", o_sec, 6'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t5.rel");
    repeat (100) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t5.hold");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t5.rel");
    checkValue("t5.hold.sec", o_sec, 6'd2);
    checkValue("t5.hold.min", o_min, 6'd0);
    checkValue("t5.hold.hour", o_hour, 6'd1);

    doReset(1'b1, "t6.reset");
    repeat (3) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "t6.held");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "t6.held");
    end
    checkValue("t6.held.mode", {4'b0, o_mode}, 6'd0);
    checkValue("t6.held.sec", o_sec, 6'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t6.rel");
    press(1'b1, 1'b0, 1'b0, "t6.repress");
    checkValue("t6.repress.mode", {4'b0, o_mode}, 6'd1);
    press(1'b0, 1'b1, 1'b0, "t6.pos");
    press(1'b0, 1'b1, 1'b0, "t6.pos");
    repeat (2) press(1'b0, 1'b0, 1'b1, "t6.up");
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t6.blink");
    checkValue("t6.pre.hour", o_hour, 6'd2);
    doReset(1'b0, "t6.midreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
